// File: rtl/data_memory_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO block: address map,
// STATUS bit layout and the UART transmitter state encoding.
package mmio_defs;

  // Upper half of the byte address that selects the MMIO window.
  localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

  // Byte offsets of the registers inside the MMIO window.
  localparam logic [15:0] TXDATA_OFS = 16'h0000;
  localparam logic [15:0] STATUS_OFS = 16'h0004;
  localparam logic [15:0] CYCLES_OFS = 16'h0008;

  // STATUS register bit positions.
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;

  // UART transmitter frame phases.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/data_memory_mmio_uart_tx_serialiser.sv
// 8N1 serialiser: takes a byte from the FIFO head when idle and shifts it
// out LSB first, framed by one start and one stop bit. The line is driven
// straight from a flop so it never glitches.
module uart_tx_serialiser
  import mmio_defs::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_pop,
  output logic       busy,
  output logic       tx
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign tx_pop    = (state == TX_IDLE) && tx_valid;
  assign busy      = (state != TX_IDLE);

  // Frame sequencer: each non-idle phase lasts CLKS_PER_BIT clocks per bit.
  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (tx_valid) begin
            shift    <= tx_byte;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            shift    <= shift >> 1;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Data-memory peer of the single-cycle core: word RAM with combinational
// read and clocked write, plus an MMIO window holding a UART TX FIFO,
// its STATUS register and a free-running cycle counter.
module data_memory_mmio
  import mmio_defs::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] data_memory_address,
  input  logic        data_memory_write_enable,
  input  logic [31:0] data_memory_write_input,
  output logic [31:0] data_memory_read_result,
  output logic        uart_tx
);

  localparam int             RAM_AW     = $clog2(RAM_WORDS);
  localparam int             FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int             CNT_W      = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Address decode. Word addresses outside the MMIO window alias into RAM.
  logic              is_mmio;
  logic [15:0]       mmio_ofs;
  logic [RAM_AW-1:0] ram_index;
  logic              push_req;
  logic              clear_ovf;

  assign is_mmio   = (data_memory_address[29:14] == MMIO_BASE_HI);
  assign mmio_ofs  = {data_memory_address[13:0], 2'b00};
  assign ram_index = data_memory_address[RAM_AW-1:0];
  assign push_req  = data_memory_write_enable && is_mmio && (mmio_ofs == TXDATA_OFS);
  assign clear_ovf = data_memory_write_enable && is_mmio && (mmio_ofs == STATUS_OFS)
                     && data_memory_write_input[STATUS_OVF_BIT];

  // RAM write port.
  // NOTE: memory arrays carry no reset; software must write before it reads.
  logic [31:0] ram [RAM_WORDS];
  always_ff @(posedge clock) begin
    if (data_memory_write_enable && !is_mmio) begin
      ram[ram_index] <= data_memory_write_input;
    end
  end

  // TX FIFO storage and status; full/empty reflect pre-edge occupancy.
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic               tx_pop;
  logic               tx_busy;
  logic               ovf;

  assign full    = (count == FIFO_FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push_req && !full;
  assign do_pop  = tx_pop && !empty;

  // FIFO data write; the array is only ever read at a valid head.
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= data_memory_write_input[7:0];
    end
  end

  // FIFO pointers and occupancy; reset empties the queue so no stale byte survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a dropped byte wins over a same-edge clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (push_req && full) begin
      ovf <= 1'b1;
    end else if (clear_ovf) begin
      ovf <= 1'b0;
    end
  end

  // Free-running cycle counter, wraps naturally.
  logic [31:0] cycles;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  uart_tx_serialiser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serialiser (
    .clock   (clock),
    .reset   (reset),
    .tx_byte (fifo_mem[rd_ptr]),
    .tx_valid(!empty),
    .tx_pop  (tx_pop),
    .busy    (tx_busy),
    .tx      (uart_tx)
  );

  // Load data mux: RAM, STATUS, CYCLES; everything else reads zero.
  // NOTE: the output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    data_memory_read_result = '0;
    if (!is_mmio) begin
      data_memory_read_result = ram[ram_index];
    end else begin
      case (mmio_ofs)
        STATUS_OFS: begin
          data_memory_read_result[STATUS_FULL_BIT]  = full;
          data_memory_read_result[STATUS_EMPTY_BIT] = empty;
          data_memory_read_result[STATUS_BUSY_BIT]  = tx_busy;
          data_memory_read_result[STATUS_OVF_BIT]   = ovf;
        end
        CYCLES_OFS: data_memory_read_result = cycles;
        default:    data_memory_read_result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM load/store and aliasing, UART
// framing of a single byte, FIFO overflow, cycle counter and reset abort.
module tb_data_memory_mmio;

  localparam int          CPB      = 4;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLES = 32'hFFFF_0008;
  localparam logic [31:0] A_HOLE   = 32'hFFFF_00F0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] addr  = '0;
  logic        we    = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx;

  int tests  = 0;
  int failed = 0;

  logic [7:0] rx_q [$];

  data_memory_mmio #(
    .RAM_WORDS   (1024),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .data_memory_address     (addr),
    .data_memory_write_enable(we),
    .data_memory_write_input (wdata),
    .data_memory_read_result (rdata),
    .uart_tx                 (uart_tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

  // One store: strobe is high across exactly one rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr  = word_of(a);
    wdata = d;
    we    = 1'b1;
    @(negedge clock);
    we    = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    addr = word_of(a);
    #1;
    d = rdata;
  endtask

  // Line monitor: decodes 8N1 frames sampled mid-bit into rx_q.
  logic       mon_active = 1'b0;
  int         mon_t      = 0;
  int         mon_k      = 0;
  logic [7:0] mon_byte   = '0;
  always @(negedge clock) begin
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
      end
    end else begin
      mon_t++;
      if (mon_t % CPB == CPB / 2) begin
        mon_k = mon_t / CPB;
        if (mon_k >= 1 && mon_k <= 8) begin
          mon_byte[mon_k-1] = uart_tx;
        end else if (mon_k == 9) begin
          check("stop_bit", {31'b0, uart_tx}, 32'd1);
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [9:0]  frame;
    int          low_cnt;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    load(A_STATUS, r);  check("rst_status", r, 32'h2);
    load(A_CYCLES, r);  check("rst_cycles", r, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    load(A_CYCLES, r);  check("cycles_first", r, 32'h1);

    // RAM store/load, aliasing, top-of-range word
    store(32'h0000_0014, 32'h1234_5678);
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load(32'h0000_0010, r);  check("ram_10", r, 32'hDEAD_BEEF);
    load(32'h0000_0014, r);  check("ram_14_unchanged", r, 32'h1234_5678);
    load(32'h0000_1010, r);  check("ram_alias_1010", r, 32'hDEAD_BEEF);
    store(32'hFFFE_FFFC, 32'hA5A5_0001);
    load(32'h0000_0FFC, r);  check("ram_top_alias", r, 32'hA5A5_0001);
    store(32'h0000_2014, 32'h0BAD_F00D);
    load(32'h0000_0014, r);  check("ram_alias_store", r, 32'h0BAD_F00D);
    load(32'h0000_0010, r);  check("ram_10_kept", r, 32'hDEAD_BEEF);

    // Unmapped MMIO reads zero and ignores stores
    store(32'h0000_00F0, 32'h600D_CAFE);
    load(A_HOLE, r);         check("hole_read", r, 32'h0);
    load(A_TXDATA, r);       check("txdata_read", r, 32'h0);
    load(32'hFFFF_000C, r);  check("mmio_0c_read", r, 32'h0);
    store(A_HOLE, 32'hFFFF_FFFF);
    load(32'h0000_00F0, r);  check("hole_no_ram_write", r, 32'h600D_CAFE);
    load(A_STATUS, r);       check("hole_status", r, 32'h2);
    low_cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) low_cnt++;
    end
    check("hole_no_tx", low_cnt, 0);

    // Cycle counter
    load(A_CYCLES, c0);
    repeat (10) @(negedge clock);
    load(A_CYCLES, c1);
    check("cycles_diff10", c1 - c0, 32'd10);
    load(A_CYCLES, c0);
    store(A_CYCLES, 32'h0);
    load(A_CYCLES, c1);
    check("cycles_wr_ignored", c1 - c0, 32'd2);

    // Single byte 0x55: exact waveform and busy flag
    rx_q.delete();
    store(A_TXDATA, 32'h55);
    check("tx_high_at_push", {31'b0, uart_tx}, 32'd1);
    load(A_STATUS, r);
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j <= 40; j++) begin
      @(negedge clock);
      if (j < 40) begin
        check($sformatf("tx55_bit_t%0d", j), {31'b0, uart_tx}, {31'b0, frame[j/4]});
        check($sformatf("tx55_busy_t%0d", j), {31'b0, rdata[2]}, 32'd1);
      end else begin
        check("tx55_idle_after", {31'b0, uart_tx}, 32'd1);
        check("tx55_busy_after", {31'b0, rdata[2]}, 32'd0);
      end
    end
    check("tx55_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("tx55_rx_byte", {24'b0, rx_q[0]}, 32'h55);

    // Burst of ten: nine sent in order, tenth dropped with overflow
    rx_q.delete();
    @(negedge clock);
    addr  = word_of(A_TXDATA);
    wdata = 32'h30;
    we    = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      wdata = 32'h30 + i;
    end
    @(negedge clock);
    we = 1'b0;
    load(A_STATUS, r);  check("status_after_burst", r, 32'hD);
    store(A_STATUS, 32'h8);
    load(A_STATUS, r);  check("status_ovf_cleared", r, 32'h5);
    for (int i = 0; i < 800 && rx_q.size() < 9; i++) @(negedge clock);
    check("burst_rx_count", rx_q.size(), 9);
    repeat (100) @(negedge clock);
    check("burst_no_extra", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      check($sformatf("burst_byte_%0d", i), {24'b0, rx_q[i]}, 32'h30 + i);
    end
    load(A_STATUS, r);  check("status_burst_done", r, 32'h2);

    // Reset in the middle of a data bit with three bytes still queued
    rx_q.delete();
    @(negedge clock);
    addr  = word_of(A_TXDATA);
    wdata = 32'h00;
    we    = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      wdata = 32'h11 * i;
    end
    @(negedge clock);
    we = 1'b0;
    repeat (6) @(negedge clock);
    load(A_STATUS, r);  check("status_mid_frame", r, 32'h4);
    check("tx_low_mid_data", {31'b0, uart_tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("tx_high_in_reset", {31'b0, uart_tx}, 32'd1);
    load(A_STATUS, r);  check("status_in_reset", r, 32'h2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    load(A_STATUS, r);  check("status_after_release", r, 32'h2);
    low_cnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) low_cnt++;
    end
    check("tx_idle_after_reset", low_cnt, 0);
    check("no_rx_after_reset", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
